dsram_responder: RTL and testbench

Data-side SRAM-style memory responder on the CPU memory-stage port. It accepts one load/store request at a time, holds `d_stall` high for a programmable number of wait cycles, and performs the word or byte-masked access on an internal word array. It then returns read data and parks until the whole pipeline advances, so a stalled request is never re-issued. It is used as the data-memory model behind the core in simulation and on small FPGA builds.

---
 rtl/dsram_responder.sv | 107 ++++++++++
 tb/tb_dsram_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dsram_responder.sv
// Data-side SRAM responder: one request at a time, programmable wait cycles,
// byte-masked writes, and a parked DONE state until the pipeline advances.
module dsram_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    input  logic        hasException,
    input  logic        longest_stall,
    output logic [31:0] data_sram_rdata,
    output logic        d_stall
);

    localparam logic [3:0] LatCnt = 4'(LATENCY);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            wen_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic [31:0]           merged;
    logic                  accept;
    logic                  access;
    logic                  stall_c;

    logic [31:0] mem [2**ADDR_WIDTH];

    // Only the word-index bits select a word; everything else aliases.
    logic unused_addr;
    assign unused_addr = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            StIdle: begin
                stall_c = data_sram_en & ~hasException;
                if (data_sram_en && !hasException) begin
                    accept  = 1'b1;
                    cnt_d   = LatCnt;
                    state_d = StWait;
                end
            end
            StWait: begin
                stall_c = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!longest_stall) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // With wen_q == 0 this is simply the stored word, so reads share the path.
    always_comb begin
        merged = mem[addr_q];
        for (int i = 0; i < 4; i++) begin
            if (wen_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            addr_q  <= '0;
            wen_q   <= 4'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= data_sram_addr[ADDR_WIDTH+1:2];
                wen_q   <= data_sram_wen;
                wdata_q <= data_sram_wdata;
            end
            if (access) rdata_q <= merged;
        end
    end

    // Memory is never reset; a reset on the access edge cancels the write.
    always_ff @(posedge clk) begin
        if (rst && access && (wen_q != 4'd0)) mem[addr_q] <= merged;
    end

    assign d_stall         = rst & stall_c;
    assign data_sram_rdata = rst ? rdata_q : 32'd0;

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder: three instances (LATENCY 2, 3, 0) checked
// every cycle against a transaction-level model of stall timing and memory contents.
module tb_dsram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst_n;
    logic [2:0]       en, exc, lstall;
    logic [2:0][3:0]  wen;
    logic [2:0][31:0] addr, wdata;
    logic [2:0]       stall_w;
    logic [2:0][31:0] rdata_w;

    logic [2:0]       exp_stall;
    logic [2:0][31:0] exp_rdata;
    logic [31:0]      mdl_mem [3][4096];
    logic             chk_on = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    dsram_responder #(.ADDR_WIDTH(12), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst_n[0]), .data_sram_en(en[0]), .data_sram_wen(wen[0]),
        .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]), .hasException(exc[0]),
        .longest_stall(lstall[0]), .data_sram_rdata(rdata_w[0]), .d_stall(stall_w[0])
    );

    dsram_responder #(.ADDR_WIDTH(12), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst_n[1]), .data_sram_en(en[1]), .data_sram_wen(wen[1]),
        .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]), .hasException(exc[1]),
        .longest_stall(lstall[1]), .data_sram_rdata(rdata_w[1]), .d_stall(stall_w[1])
    );

    dsram_responder #(.ADDR_WIDTH(12), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst_n[2]), .data_sram_en(en[2]), .data_sram_wen(wen[2]),
        .data_sram_addr(addr[2]), .data_sram_wdata(wdata[2]), .hasException(exc[2]),
        .longest_stall(lstall[2]), .data_sram_rdata(rdata_w[2]), .d_stall(stall_w[2])
    );

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    // Per-cycle comparison of every instance against the model's expectations.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (stall_w[k] !== exp_stall[k]) begin
                    miscompares++;
                    $display("FAIL d_stall inst%0d t=%0t: got %b, want %b",
                             k, $time, stall_w[k], exp_stall[k]);
                end
                vectors++;
                if (rdata_w[k] !== exp_rdata[k]) begin
                    miscompares++;
                    $display("FAIL rdata inst%0d t=%0t: got %h, want %h",
                             k, $time, rdata_w[k], exp_rdata[k]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            en[k]        = 1'b0;
            wen[k]       = 4'd0;
            exc[k]       = 1'b0;
            lstall[k]    = 1'b0;
            exp_stall[k] = 1'b0;
        end
    endtask

    task automatic check_lit(input int k, input string name, input logic [31:0] want);
        @(negedge clk);
        vectors++;
        if (rdata_w[k] !== want) begin
            miscompares++;
            $display("FAIL %s inst%0d: got %h, want %h", name, k, rdata_w[k], want);
        end
    endtask

    // One full transaction: accept, LATENCY+1 wait cycles with scrambled bus
    // inputs, then 1+hold DONE cycles. Ends in the last DONE cycle.
    task automatic req(input int k, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input int hold, input logic [31:0] lit);
        int unsigned wi;
        logic [31:0] res;
        wi = 32'(a[13:2]);
        step();
        en[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d;
        exc[k] = 1'b0; lstall[k] = 1'b1; exp_stall[k] = 1'b1;
        for (int i = 0; i <= lat_of(k); i++) begin
            step();
            wdata[k] = ~d; wen[k] = ~w; addr[k] = a ^ 32'h10; exc[k] = 1'b1;
        end
        step();
        wdata[k] = d; wen[k] = w; addr[k] = a; exc[k] = 1'b0;
        res = mdl_mem[k][wi];
        for (int b = 0; b < 4; b++) begin
            if (w[b]) res[8*b +: 8] = d[8*b +: 8];
        end
        mdl_mem[k][wi] = res;
        exp_stall[k] = 1'b0;
        exp_rdata[k] = res;
        lstall[k]    = (hold > 0);
        check_lit(k, "done_rdata", lit);
        for (int h = 1; h <= hold; h++) begin
            step();
            lstall[k] = (h < hold);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4096; i++) mdl_mem[k][i] = 32'd0;
        end
        rst_n = 3'b000; en = '0; exc = '0; lstall = '0;
        wen = '0; addr = '0; wdata = '0;
        exp_stall = '0; exp_rdata = '0;
        step();
        chk_on = 1'b1;
        step(); step();
        rst_n = 3'b111;
        idle(0, 2);

        // LATENCY 2: preload, read, byte writes, back-to-back, DONE hold
        req(0, 4'hF, 32'h14, 32'hDEADBEEF, 0, 32'hDEADBEEF); idle(0, 1);
        req(0, 4'hF, 32'h04, 32'h11223344, 0, 32'h11223344); idle(0, 1);
        req(0, 4'h0, 32'h14, 32'h0,        0, 32'hDEADBEEF); idle(0, 1);
        req(0, 4'b0010, 32'h04, 32'h0000AA00, 0, 32'h1122AA44); idle(0, 1);
        req(0, 4'h0, 32'h04, 32'h0,        0, 32'h1122AA44);
        req(0, 4'b1001, 32'h04, 32'hFF0000EE, 0, 32'hFF22AAEE); idle(0, 1);
        req(0, 4'hF, 32'h08, 32'h1,        3, 32'h1);        idle(0, 2);
        req(0, 4'h0, 32'h08, 32'h0,        0, 32'h1);        idle(0, 1);

        // Exception in IDLE: no stall, no write
        step();
        en[0] = 1'b1; wen[0] = 4'hF; addr[0] = 32'h14; wdata[0] = 32'h0BADF00D;
        exc[0] = 1'b1; exp_stall[0] = 1'b0;
        idle(0, 2);
        req(0, 4'h0, 32'h14, 32'h0, 0, 32'hDEADBEEF); idle(0, 1);

        // LATENCY 3: reset one cycle after acceptance aborts the write
        req(1, 4'hF, 32'h0C, 32'h13572468, 0, 32'h13572468); idle(1, 1);
        step();
        en[1] = 1'b1; wen[1] = 4'hF; addr[1] = 32'h0C; wdata[1] = 32'hCAFEF00D;
        lstall[1] = 1'b1; exp_stall[1] = 1'b1;
        step();
        rst_n[1] = 1'b0; en[1] = 1'b0; exp_stall[1] = 1'b0; exp_rdata[1] = 32'd0;
        step();
        rst_n[1] = 1'b1;
        check_lit(1, "post_reset_rdata", 32'd0);
        idle(1, 1);
        req(1, 4'h0, 32'h0C, 32'h0, 0, 32'h13572468); idle(1, 1);

        // LATENCY 0 plus upper-address aliasing
        req(2, 4'hF, 32'h14, 32'h5A5A0F0F, 0, 32'h5A5A0F0F); idle(2, 1);
        req(2, 4'h0, 32'h4014, 32'h0, 0, 32'h5A5A0F0F);      idle(2, 1);
        req(2, 4'b0100, 32'h8014, 32'h00C30000, 0, 32'h5AC30F0F); idle(2, 1);
        req(2, 4'h0, 32'h14, 32'h0, 0, 32'h5AC30F0F);        idle(2, 2);

        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
